// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial sequencer driving one external ALU_bitslice.
// Feeds the slice one operand bit pair per cycle, LSB first, and collects
// fout into a result shift register. cout is registered and becomes the
// next cycle's cin. Offers a start/busy/done handshake to the controller.
// Optional build macro: ALU_SEQ_FLAGS_EN adds registered zero/overflow outputs.
module alu_serial_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op_ctrl,
   input  logic             op_sub,
   input  logic             op_cin,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_cin,
   output logic [1:0]       slice_ctrl,
   input  logic             slice_fout,
   input  logic             slice_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
`ifdef ALU_SEQ_FLAGS_EN
   ,
   output logic             zero,
   output logic             overflow
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-2:0] sr_q;
   logic [WIDTH-1:0] sr_d;
   logic [WIDTH-1:0] result_q;
   logic [1:0]       ctrl_q;
   logic             sub_q;
   logic             cin_q;
   logic             busy_q;
   logic             done_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             last_bit;
`ifdef ALU_SEQ_FLAGS_EN
   logic             zero_q;
   logic             ovf_q;
`endif

   // Shift-in value and last-bit detect for the current SHIFT cycle.
   // sr_q holds only the upper WIDTH-1 bits; the final fout completes sr_d,
   // which is what gets committed to result on the last bit.
   always_comb begin
      sr_d     = {slice_fout, sr_q};
      last_bit = (cnt_q == CW'(WIDTH - 1));
   end

   // Slice drive: register LSBs while shifting, all zero otherwise.
   always_comb begin
      slice_a    = 1'b0;
      slice_b    = 1'b0;
      slice_cin  = 1'b0;
      slice_ctrl = 2'b00;
      if (state_q == SHIFT) begin
         slice_a    = a_q[0];
         slice_b    = b_q[0] ^ sub_q;
         slice_cin  = cin_q;
         slice_ctrl = ctrl_q;
      end
   end

   // Sequencer FSM with registered handshake and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sr_q     <= '0;
         result_q <= '0;
         ctrl_q   <= 2'b00;
         sub_q    <= 1'b0;
         cin_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
`ifdef ALU_SEQ_FLAGS_EN
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a_in;
                  b_q     <= b_in;
                  sr_q    <= '0;
                  ctrl_q  <= op_ctrl;
                  sub_q   <= op_sub & (op_ctrl == 2'b00);
                  cin_q   <= op_cin | (op_sub & (op_ctrl == 2'b00));
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               sr_q  <= sr_d[WIDTH-1:1];
               cin_q <= slice_cout;
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               cnt_q <= cnt_q + CW'(1);
               if (last_bit) begin
                  // Commit on entry to DONE so result is visible with done.
                  result_q <= sr_d;
                  carry_q  <= slice_cout;
`ifdef ALU_SEQ_FLAGS_EN
                  zero_q   <= (sr_d == '0);
                  ovf_q    <= (ctrl_q == 2'b00) & (cin_q ^ slice_cout);
`endif
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign carry_out = carry_q;
`ifdef ALU_SEQ_FLAGS_EN
   assign zero      = zero_q;
   assign overflow  = ovf_q;
`endif

endmodule
